// File: rtl/joystick_pkg.sv
// Shared types and constants for the joystick debounce array.
// The auto-repeat engine is built only when JOYSTICK_REPEAT_EN is defined.
package joystick_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } rep_state_e;

  localparam int unsigned CH_RIGHT = 0;
  localparam int unsigned CH_DOWN  = 1;
  localparam int unsigned CH_UP    = 2;
  localparam int unsigned CH_LEFT  = 3;
  localparam int unsigned CH_FIRE  = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, counter debounce, edge pulses and,
// with JOYSTICK_REPEAT_EN defined, a hold-to-auto-repeat pulse generator.
module debounce_channel
  import joystick_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic                   p_s;
  logic                   s_s;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;

  // Next-state logic for synchroniser, debounce counter and edge pulses.
  always_comb begin
    p_s       = (ACTIVE_LOW != 0) ? ~i_pin : i_pin;
    sync_d    = {sync_q[SYNC_STAGES-2:0], p_s};
    s_s       = sync_q[SYNC_STAGES-1];
    cnt_d     = cnt_q;
    level_d   = level_q;
    if (s_s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      level_d = s_s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    // Pulses look at the next level so they coincide with the level flip.
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;

`ifdef JOYSTICK_REPEAT_EN
  localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  rep_state_e    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          repeat_q, repeat_d;

  // Repeat FSM: a falling level always wins over a due repeat.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    repeat_d = 1'b0;
    if (!level_d) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = HELD_DELAY;
          rcnt_d  = '0;
        end
        HELD_DELAY: begin
          if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
            repeat_d = 1'b1;
            rcnt_d   = '0;
            state_d  = HELD_REPEAT;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        HELD_REPEAT: begin
          if (rcnt_q == RW'(REPEAT_PERIOD - 1)) begin
            repeat_d = 1'b1;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  // Repeat FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rcnt_q   <= '0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      repeat_q <= repeat_d;
    end
  end

  assign o_repeat = repeat_q;
`else
  assign o_repeat = 1'b0;
`endif

endmodule

// File: rtl/joystick_debounce_array.sv
// N_CH independent debounced joystick channels with press/release/repeat pulses.
// Auto-repeat is present only when JOYSTICK_REPEAT_EN is defined.
module joystick_debounce_array
  import joystick_pkg::*;
#(
  parameter int unsigned N_CH            = 5,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_pin,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_repeat,
  output logic            o_any_press,
  output logic [N_CH-1:0] o_led
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_pin    (i_pin[g]),
      .o_level  (o_level[g]),
      .o_press  (o_press[g]),
      .o_release(o_release[g]),
      .o_repeat (o_repeat[g])
    );
  end

  assign o_any_press = |o_press;
  assign o_led       = o_level;

endmodule

// File: tb/tb_joystick_debounce_array.sv
// Scoreboard bench: a window-based reference model predicts every cycle's outputs.
// Repeat expectations follow JOYSTICK_REPEAT_EN the same way the design does.
module tb_joystick_debounce_array;

  localparam int N    = 5;
  localparam int S    = 2;
  localparam int D    = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int MAXE = 4096;
  localparam logic [N-1:0] ALL_UP = 5'b11111;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] i_pin = ALL_UP;
  logic [N-1:0] o_level, o_press, o_release, o_repeat, o_led;
  logic         o_any_press;

  joystick_debounce_array #(
    .N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .i_pin(i_pin), .o_level(o_level), .o_press(o_press),
    .o_release(o_release), .o_repeat(o_repeat), .o_any_press(o_any_press), .o_led(o_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           e;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] rep;
    logic         any;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: pressed-domain samples per edge and event bookkeeping.
  logic [N-1:0] p_at [MAXE];
  int           k_e      = -1;
  int           last_rst = -1;
  logic [N-1:0] lvl      = '0;
  int           last_flip [N];
  int           press_e   [N];

  // Synchronised value seen by the debouncer at edge j.
  function automatic logic s_at(input int j, input int c);
    if (j - S < 0 || j - S <= last_rst) return 1'b0;
    return p_at[j-S][c];
  endfunction

  task automatic model_edge(input logic [N-1:0] pins, input logic r);
    exp_t x;
    logic flip;
    k_e++;
    x.e = k_e; x.press = '0; x.rel = '0; x.rep = '0;
    if (r) begin
      p_at[k_e] = '0;
      last_rst  = k_e;
      lvl       = '0;
    end else begin
      p_at[k_e] = ~pins;
      for (int c = 0; c < N; c++) begin
        // Level flips once the last D samples since any reset/flip all disagree with it.
        flip = (k_e - D + 1 > last_rst) && (k_e - D + 1 > last_flip[c]);
        for (int j = k_e - D + 1; j <= k_e; j++)
          if (flip && s_at(j, c) == lvl[c]) flip = 1'b0;
        if (flip) begin
          lvl[c]       = ~lvl[c];
          last_flip[c] = k_e;
          if (lvl[c]) begin
            x.press[c] = 1'b1;
            press_e[c] = k_e;
          end else begin
            x.rel[c] = 1'b1;
          end
        end
`ifdef JOYSTICK_REPEAT_EN
        if (lvl[c] && !x.press[c]) begin
          int d;
          d = k_e - press_e[c];
          if (d == RD || (d > RD && (d - RD) % RP == 0)) x.rep[c] = 1'b1;
        end
`endif
      end
    end
    x.level = lvl;
    x.any   = |x.press;
    q.push_back(x);
  endtask

  task automatic step(input logic [N-1:0] pins, input logic r);
    @(negedge clk);
    i_pin = pins;
    rst   = r;
    model_edge(pins, r);
  endtask

  task automatic hold(input logic [N-1:0] pins, input int n);
    for (int i = 0; i < n; i++) step(pins, 1'b0);
  endtask

  task automatic chk(input string nm, input int e, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b, expected %b", nm, e, got, exp);
    end
  endtask

  // Monitor: compare DUT outputs after each active edge against the queued prediction.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("level",   x.e, o_level,   x.level);
        chk("press",   x.e, o_press,   x.press);
        chk("release", x.e, o_release, x.rel);
        chk("repeat",  x.e, o_repeat,  x.rep);
        chk("led",     x.e, o_led,     x.level);
        chk("any_press", x.e, {{(N-1){1'b0}}, o_any_press}, {{(N-1){1'b0}}, x.any});
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] rp;
    int           hl [N];
    for (int c = 0; c < N; c++) begin
      last_flip[c] = -1000000;
      press_e[c]   = 0;
      hl[c]        = 0;
    end
    rp = ALL_UP;

    for (int i = 0; i < 3; i++) step(ALL_UP, 1'b1);
    hold(ALL_UP, 5);
    // Clean press on fire.
    hold(5'b01111, 20); hold(ALL_UP, 10);
    // Bounce on right: 2-cycle runs never reach the debounce count.
    for (int i = 0; i < 3; i++) begin hold(5'b11110, 2); hold(ALL_UP, 2); end
    hold(ALL_UP, 10);
    // Auto-repeat on up, released away from a repeat slot.
    hold(5'b11011, 30); hold(ALL_UP, 12);
    // Release lands exactly on a due repeat (press+16).
    hold(5'b11011, 16); hold(ALL_UP, 12);
    // Simultaneous down and left.
    hold(5'b10101, 10); hold(ALL_UP, 10);
    // Reset while up is in the repeat phase, pin kept low across it.
    hold(5'b11011, 20); step(5'b11011, 1'b1); hold(5'b11011, 15); hold(ALL_UP, 12);
    // Random hold lengths per channel with occasional resets.
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N; c++) begin
        if (hl[c] == 0) begin
          rp[c] = 1'($urandom_range(0, 1));
          hl[c] = int'($urandom_range(1, 25));
        end
        hl[c]--;
      end
      step(rp, ($urandom_range(0, 199) == 0));
    end
    hold(ALL_UP, 10);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
